// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path definitions: frame length limits, write-FSM states, buffer entry layout.
package eth_pkg;

    localparam int ETH_MIN_LEN = 60;
    localparam int ETH_MAX_LEN = 1518;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } buf_entry_t;

endpackage

// File: rtl/rx_frame_ram.sv
// Simple dual-port 2^ADDR_W x 9 frame buffer; one write port, one registered read port.
// Read data appears the cycle after rd_en_i and is held while rd_en_i is low.
module rx_frame_ram #(
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [8:0]        wr_dat_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [8:0]        rd_dat_o
);

    logic [8:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/rx_axis_adapter.sv
// Store-and-forward MAC rx bytes into AXI-Stream; only complete, error-free, in-range frames are replayed.
// tvalid rises 2 cycles after commit; 1 byte/cycle while tready; output held under backpressure. RX_AXIS_STATS_EN adds counters.
module rx_axis_adapter
    import eth_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN
) (
    input  logic        clk_mac,
    input  logic        rst_n,
    input  logic        rx_vld,
    input  logic [7:0]  rx_dat,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic [10:0] rx_len,
    input  logic        rx_err,
    output logic [7:0]  rx_axis_mac_tdata,
    output logic        rx_axis_mac_tvalid,
    output logic        rx_axis_mac_tlast,
    input  logic        rx_axis_mac_tready,
    output logic        rx_ovf,
    output logic        rx_drop
`ifdef RX_AXIS_STATS_EN
    ,
    output logic [15:0] rx_good_cnt,
    output logic [15:0] rx_drop_cnt
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_DIFF = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [10:0]     MIN_L     = 11'(MIN_LEN);
    localparam logic [10:0]     MAX_L     = 11'(MAX_LEN);

    wr_state_e       state_q, state_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] wr_commit_q, wr_commit_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            drop_q, drop_d;
    logic            ovf_q, ovf_d;
    logic            commit_ev;

    logic            ram_vld_q, ram_vld_d;
    logic            out_vld_q, out_vld_d;
    logic [7:0]      out_dat_q, out_dat_d;
    logic            out_last_q, out_last_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    buf_entry_t        wr_entry;
    logic              rd_en;
    buf_entry_t        rd_entry;

    logic            restart;
    logic [ADDR_W:0] base_ptr;
    logic            full;
    logic            len_ok;
    logic            empty;
    logic            out_load;

    // A sof inside RECV rolls back to wr_commit before the new byte is written.
    assign restart  = rx_vld && rx_sof && (state_q == RECV);
    assign base_ptr = restart ? wr_commit_q : wr_ptr_q;
    assign full     = (base_ptr - rd_ptr_q) == FULL_DIFF;
    assign len_ok   = !rx_err && (rx_len >= MIN_L) && (rx_len <= MAX_L);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        drop_d      = 1'b0;
        ovf_d       = 1'b0;
        commit_ev   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = base_ptr[ADDR_W-1:0];
        wr_entry    = '{last: rx_eof, data: rx_dat};

        case (state_q)
            DROP: begin
                if (rx_vld && rx_eof) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (rx_vld && (rx_sof || state_q == RECV)) begin
                    if (restart) begin
                        drop_d   = 1'b1;
                        wr_ptr_d = wr_commit_q;
                    end
                    if (full) begin
                        wr_ptr_d = wr_commit_q;
                        ovf_d    = 1'b1;
                        drop_d   = 1'b1;
                        state_d  = rx_eof ? IDLE : DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (rx_eof) begin
                            state_d = IDLE;
                            if (len_ok) begin
                                wr_ptr_d    = base_ptr + PTR_ONE;
                                wr_commit_d = base_ptr + PTR_ONE;
                                commit_ev   = 1'b1;
                            end else begin
                                wr_ptr_d = wr_commit_q;
                                drop_d   = 1'b1;
                            end
                        end else begin
                            wr_ptr_d = base_ptr + PTR_ONE;
                            state_d  = RECV;
                        end
                    end
                end
            end
        endcase
    end

    // Two-stage read pipeline: RAM output register, then the AXIS output register.
    assign empty    = (rd_ptr_q == wr_commit_q);
    assign out_load = ram_vld_q && (!out_vld_q || rx_axis_mac_tready);

    always_comb begin
        rd_en      = !empty && (!ram_vld_q || out_load);
        rd_ptr_d   = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        ram_vld_d  = rd_en || (ram_vld_q && !out_load);
        out_vld_d  = out_load || (out_vld_q && !rx_axis_mac_tready);
        out_dat_d  = out_load ? rd_entry.data : out_dat_q;
        out_last_d = out_load ? rd_entry.last : out_last_q;
    end

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            drop_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ram_vld_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
            ram_vld_q   <= ram_vld_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            out_last_q  <= out_last_d;
        end
    end

    rx_frame_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i     (clk_mac),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_dat_i  (wr_entry),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_dat_o  (rd_entry)
    );

    assign rx_axis_mac_tdata  = out_dat_q;
    assign rx_axis_mac_tvalid = out_vld_q;
    assign rx_axis_mac_tlast  = out_last_q;
    assign rx_ovf             = ovf_q;
    assign rx_drop            = drop_q;

`ifdef RX_AXIS_STATS_EN
    logic [15:0] good_cnt_q, drop_cnt_q;

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (commit_ev && good_cnt_q != 16'hFFFF) begin
                good_cnt_q <= good_cnt_q + 16'd1;
            end
            if (drop_d && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign rx_good_cnt = good_cnt_q;
    assign rx_drop_cnt = drop_cnt_q;
`endif

endmodule
